// File: rtl/pc_stack_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and defaults for the program-counter / return-stack unit.
//   pc_op_e  : the single operation selected for a cycle
//   pc_sel() : fixed-priority encode of the raw control strobes
//              (ret > call > load > branch > inc, otherwise hold)
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_ADDR_W_DEF      = 8;
    localparam int PC_STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Only the highest-priority strobe survives; the others are dropped.
    function automatic pc_op_e pc_sel(
        input logic ret,
        input logic call,
        input logic load,
        input logic branch,
        input logic inc
    );
        pc_op_e op;
        if (ret)         op = PC_RET;
        else if (call)   op = PC_CALL;
        else if (load)   op = PC_LOAD;
        else if (branch) op = PC_BRANCH;
        else if (inc)    op = PC_INC;
        else             op = PC_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// ---------------------------------------------------------------------------
// pc_stack_unit_if
// Bundle between the control-unit FSM (master) and the PC unit (slave).
//   master drives : en, inc, load, branch, call, ret, target, offset, err_clr
//   slave drives  : pc, depth, stk_full, stk_empty, ovf_err, unf_err
// ---------------------------------------------------------------------------
interface pc_stack_unit_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               en;
    logic               inc;
    logic               load;
    logic               branch;
    logic               call;
    logic               ret;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  offset;
    logic               err_clr;

    logic [ADDR_W-1:0]  pc;
    logic [DEPTH_W-1:0] depth;
    logic               stk_full;
    logic               stk_empty;
    logic               ovf_err;
    logic               unf_err;

    modport master (
        output en, inc, load, branch, call, ret, target, offset, err_clr,
        input  pc, depth, stk_full, stk_empty, ovf_err, unf_err
    );

    modport slave (
        input  en, inc, load, branch, call, ret, target, offset, err_clr,
        output pc, depth, stk_full, stk_empty, ovf_err, unf_err
    );

endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// ---------------------------------------------------------------------------
// pc_ret_stack
// LIFO of return addresses.
//   clk, reset (async, active-low)
//   push_i / wdata_i : write wdata_i on top (ignored when full)
//   pop_i            : discard top entry (ignored when empty)
//   rdata_o          : current top entry (meaningless while empty)
//   depth_o, full_o, empty_o : occupancy, decoded from the registered depth
// Entries are not reset; only the depth counter is.
// ---------------------------------------------------------------------------
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEF,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push_i,
    input  logic                               pop_i,
    input  logic [ADDR_W-1:0]                  wdata_i,
    output logic [ADDR_W-1:0]                  rdata_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
    output logic                               full_o,
    output logic                               empty_o
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]      mem_q [STACK_DEPTH];
    logic [DEPTH_W-1:0]     depth_q;
    logic [DEPTH_W-1:0]     depth_d;
    logic [STACK_DEPTH-1:0] wr_sel;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The next free slot is at index depth; only valid while not full.
    assign wr_idx = IDX_W'(depth_q);
    // Clamp while empty so the read index never leaves the array.
    assign rd_idx = empty_o ? '0 : IDX_W'(depth_q - DEPTH_W'(1));

    // One-hot write select per entry.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_push && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
// Program counter for the fetch path with relative branch and call/return
// through an internal return-address stack.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : pc_stack_unit_if.slave
//            strobes en/inc/load/branch/call/ret, target, offset, err_clr in;
//            pc, depth, stk_full, stk_empty, ovf_err, unf_err out
// en low freezes everything, including the sticky error flags.
// ---------------------------------------------------------------------------
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W_DEF,
    parameter int                STACK_DEPTH = PC_STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input logic            clk,
    input logic            reset,
    pc_stack_unit_if.slave bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    pc_op_e             op;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [ADDR_W-1:0]  stk_rdata;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               stk_push;
    logic               stk_pop;
    logic               ovf_q;
    logic               ovf_d;
    logic               unf_q;
    logic               unf_d;

    // A stalled cycle is simply a hold.
    assign op = bus.en ? pc_sel(bus.ret, bus.call, bus.load, bus.branch, bus.inc)
                       : PC_HOLD;

    // Natural ADDR_W-bit wrap gives the modulo arithmetic.
    assign pc_plus1 = pc_q + ADDR_W'(1);

    assign stk_push = (op == PC_CALL) && !stk_full;
    assign stk_pop  = (op == PC_RET) && !stk_empty;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .wdata_i (pc_plus1),
        .rdata_o (stk_rdata),
        .depth_o (stk_depth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Next PC. Calls on a full stack and returns on an empty stack leave
    // the PC alone; only the matching error flag reacts.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_INC:    pc_d = pc_plus1;
            PC_BRANCH: pc_d = pc_q + bus.offset;
            PC_LOAD:   pc_d = bus.target;
            PC_CALL:   if (!stk_full)  pc_d = bus.target;
            PC_RET:    if (!stk_empty) pc_d = stk_rdata;
            default:   pc_d = pc_q;
        endcase
    end

    // Sticky flags: the clear is applied first so that a fresh error in the
    // same cycle overrides it.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.en && bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if ((op == PC_CALL) && stk_full) begin
            ovf_d = 1'b1;
        end
        if ((op == PC_RET) && stk_empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_ADDR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.depth     = stk_depth;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.ovf_err   = ovf_q;
    assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit
// Directed scenarios followed by random strobes. Each driven cycle steps a
// behavioural model (integer PC, queue as the stack) and queues the expected
// post-edge state; a monitor compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_pc_stack_unit;

    localparam int AW = 8;
    localparam int SD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_stack_unit_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();

    pc_stack_unit #(
        .ADDR_W      (AW),
        .STACK_DEPTH (SD),
        .RESET_ADDR  (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    pc;
        int    depth;
        bit    ovf;
        bit    unf;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    txn      = 0;

    // Reference model state
    int    m_pc;
    int    m_stack[$];
    bit    m_ovf;
    bit    m_unf;

    function automatic void model_reset();
        m_pc  = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit i, bit l, bit b, bit c, bit r,
                                       int t, int o, bit ec);
        if (!e) return;
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (r) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else                     m_pc  = m_stack.pop_back();
        end else if (c) begin
            if (m_stack.size() == SD) m_ovf = 1'b1;
            else begin
                m_stack.push_back((m_pc + 1) % 256);
                m_pc = t;
            end
        end else if (l) begin
            m_pc = t;
        end else if (b) begin
            m_pc = (m_pc + o) % 256;
        end else if (i) begin
            m_pc = (m_pc + 1) % 256;
        end
    endfunction

    function automatic exp_t snap(string tag);
        exp_t e;
        e.pc    = m_pc;
        e.depth = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.tag   = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk({e.tag, ".pc"},        32'(bus.pc),        32'(e.pc));
        chk({e.tag, ".depth"},     32'(bus.depth),     32'(e.depth));
        chk({e.tag, ".stk_full"},  32'(bus.stk_full),  32'(e.depth == SD));
        chk({e.tag, ".stk_empty"}, 32'(bus.stk_empty), 32'(e.depth == 0));
        chk({e.tag, ".ovf_err"},   32'(bus.ovf_err),   32'(e.ovf));
        chk({e.tag, ".unf_err"},   32'(bus.unf_err),   32'(e.unf));
        $display("txn %0d %s pc=%02h depth=%0d ovf=%0b unf=%0b (exp pc=%02h depth=%0d)",
                 txn, e.tag, bus.pc, bus.depth, bus.ovf_err, bus.unf_err, e.pc, e.depth);
        txn++;
    endtask

    // One driven cycle: inputs set at the falling edge, applied at the next
    // rising edge, checked by the monitor just after it.
    task automatic drive(input bit e, input bit i, input bit l, input bit b,
                         input bit c, input bit r, input int t, input int o,
                         input bit ec, input string tag);
        @(negedge clk);
        bus.en      = e;
        bus.inc     = i;
        bus.load    = l;
        bus.branch  = b;
        bus.call    = c;
        bus.ret     = r;
        bus.target  = 8'(t);
        bus.offset  = 8'(o);
        bus.err_clr = ec;
        model_step(e, i, l, b, c, r, t, o, ec);
        exp_q.push_back(snap(tag));
    endtask

    task automatic clear_inputs();
        bus.en = 1'b0; bus.inc = 1'b0; bus.load = 1'b0; bus.branch = 1'b0;
        bus.call = 1'b0; bus.ret = 1'b0; bus.target = '0; bus.offset = '0;
        bus.err_clr = 1'b0;
    endtask

    // Monitor: the unit produces a result every clock, so every pending
    // expectation is consumed one per rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_all(mon_e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(snap("reset_init"));
        @(negedge clk);
        reset = 1'b1;

        // Wrap-around on increment
        drive(1,0,1,0,0,0,'hFE,0,0,"load_fe");
        for (int k = 0; k < 3; k++) drive(1,1,0,0,0,0,0,0,0,"inc_wrap");

        // Priority
        drive(1,1,1,0,0,0,'h40,0,0,"load_over_inc");
        drive(1,0,1,0,0,0,'h10,0,0,"load_10");
        drive(1,0,0,0,1,0,'h77,0,0,"call_77");
        drive(1,0,0,0,1,1,'h99,0,0,"ret_over_call");

        // Branch, including a stalled branch
        drive(1,0,1,0,0,0,'h10,0,0,"load_10b");
        drive(1,0,0,1,0,0,0,'hFD,0,"branch_fd");
        drive(1,0,0,1,0,0,0,'h05,0,"branch_05");
        drive(0,0,0,1,0,0,0,'h05,0,"branch_stalled");

        // Call / return pair
        drive(1,0,1,0,0,0,'h20,0,0,"load_20");
        drive(1,0,0,0,1,0,'h80,0,0,"call_80");
        drive(1,0,0,0,0,1,0,0,0,"ret_21");

        // Overflow, then underflow
        for (int k = 0; k < 5; k++) drive(1,0,0,0,1,0,'hA0 + k,0,0,"call_fill");
        for (int k = 0; k < 5; k++) drive(1,0,0,0,0,1,0,0,0,"ret_drain");
        drive(0,0,0,0,0,0,0,0,1,"clr_stalled");
        drive(1,0,0,0,0,1,0,0,1,"clr_vs_unf");
        drive(1,0,0,0,0,0,0,0,1,"err_clr");

        // Reset asserted mid-run with pc=0x37, depth=2
        drive(1,0,1,0,0,0,'h30,0,0,"load_30");
        drive(1,0,0,0,1,0,'h50,0,0,"call_50");
        drive(1,0,0,0,1,0,'h60,0,0,"call_60");
        drive(1,0,1,0,0,0,'h37,0,0,"load_37");
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(snap("reset_async"));
        bus.call = 1'b1;
        bus.inc  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(snap("reset_held"));
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;

        // Random strobes against the model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 15) == 0,
                  "rand");
        end
        drive(0,0,0,0,0,0,0,0,0,"idle");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parameterised program-counter unit for the instruction-fetch path. It adds relative branch, and subroutine call/return backed by an internal LIFO return-address stack. It also adds a fetch-stall enable and sticky stack-error flags. It drives the fetch address to instruction memory and takes its control strobes from the control-unit FSM.

Parameters:
ADDR_W, 8, width of PC, load/call targets and branch offset
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, PC value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  global advance enable; low = stall, all state held
inc  input  1  PC <= PC+1
load  input  1  PC <= target
branch  input  1  PC <= PC + offset (two's complement)
call  input  1  push PC+1, PC <= target
ret  input  1  PC <= popped return address
target  input  ADDR_W  absolute address for load/call
offset  input  ADDR_W  signed relative offset for branch
err_clr  input  1  clears sticky error flags
pc  output  ADDR_W  current fetch address (registered)
depth  output  $clog2(STACK_DEPTH+1)  occupied stack entries
stk_full  output  1  depth == STACK_DEPTH
stk_empty  output  1  depth == 0
ovf_err  output  1  sticky: call attempted when full
unf_err  output  1  sticky: ret attempted when empty

Behaviour:
- Reset is asynchronous, active-low, on clk, reset. While reset is low: pc=RESET_ADDR, depth=0, stk_empty=1, stk_full=0, ovf_err=0, unf_err=0. Stack contents are don't-care.
- All updates occur on rising clk when reset=1 and en=1. With en=0 everything holds, including error flags; err_clr is also ignored.
- Single-cycle latency: a strobe sampled at edge N is visible on pc after edge N.
- Fixed priority when several strobes are high: ret > call > load > branch > inc. Only the highest-priority strobe acts; the rest are discarded. No strobe = hold.
- Arithmetic is modulo 2^ADDR_W. inc at all-ones wraps to 0. branch sums are truncated to ADDR_W bits, e.g. 0x02 + 0xFC = 0xFE.
- call (not full): mem[depth] <= pc+1 (wrapping), depth+1, pc <= target.
- call (full): pc and stack unchanged, ovf_err <= 1.
- ret (not empty): pc <= mem[depth-1], depth-1.
- ret (empty): pc and stack unchanged, unf_err <= 1.
- err_clr clears both flags. If err_clr and a new error occur in the same cycle, the set wins.
- stk_full and stk_empty are combinational decodes of registered depth.
- Internal state: pc register, depth counter, and the STACK_DEPTH×ADDR_W storage array. No additional FSM.
- Reset asserted mid-operation aborts any strobe in flight; no partial push or pop survives.

Decomposition:
- Shared package pc_pkg:
  - enum pc_op_e {PC_HOLD, PC_INC, PC_BRANCH, PC_LOAD, PC_CALL, PC_RET}, built by a priority-encode function pc_sel().
  - Default width constants.
- Sub-module pc_ret_stack (parameterised LIFO):
  - Inputs: push, pop, wdata.
  - Outputs: rdata (top of stack), depth, full, empty.
  - Ignores push-when-full and pop-when-empty; the parent raises the error flags.

Test Plan:
- Reset: drive reset low mid-run with pc=0x37 and depth=2 -> immediately pc=0x00, depth=0, stk_empty=1, flags 0, with no clock edge required.
- Wrap: load 0xFE, then inc ×3 -> pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Priority:
  - load=1, inc=1, target=0x40 -> pc=0x40.
  - ret+call together with depth=1 (top entry 0x11) -> pc=0x11, depth=0.
- Branch: pc=0x10, offset=0xFD -> 0x0D; then offset=0x05 -> 0x12. Repeat with en=0 -> pc holds at 0x12.
- Call/return: pc=0x20, call target 0x80 -> pc=0x80, depth=1; ret -> pc=0x21, depth=0.
- Stack errors (STACK_DEPTH=4):
  - 5 consecutive calls -> depth=4, stk_full=1, ovf_err=1, pc = 4th target.
  - 5 rets -> return addresses popped in reverse order, unf_err=1.
  - err_clr -> both flags 0.
